// File: rtl/cram_writer.sv
//==============================================================================
// Module      : cram_writer
// Description : Single write port arbiter for a 256 x 16 colour RAM. It merges
//               two write sources onto one port:
//                 - Z80 byte writes through a 512-byte window. An even byte is
//                   latched. An odd byte completes the 16-bit word and writes it.
//                 - A fill engine that writes a run of consecutive entries with
//                   either a constant word or a ramp. The ramp increments
//                   bits [14:0] and holds bit 15, the VDAC mode flag.
//               A CPU word write always wins the port. The fill engine stalls
//               in place for that cycle and resumes on the next cycle.
// Ports       : clk, rst               - clock, async active-high reset
//               cpu_wr/addr/data       - Z80 byte-write strobe, address, data
//               fill_start/base/len/
//               fill_data/fill_ramp    - fill request and its parameters
//               cram_addr/data/we      - registered CRAM write port
//               fill_busy, fill_done   - fill engine status
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cram_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr,
    input  logic [8:0]  cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        fill_start,
    input  logic [7:0]  fill_base,
    input  logic [7:0]  fill_len,
    input  logic [15:0] fill_data,
    input  logic        fill_ramp,
    output logic [7:0]  cram_addr,
    output logic [15:0] cram_data,
    output logic        cram_we,
    output logic        fill_busy,
    output logic        fill_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  lo_latch;    // last even byte written by the CPU
    logic [7:0]  fill_ptr;    // word address of the next fill write
    logic [15:0] fill_val;    // data of the next fill write
    logic [7:0]  fill_rem;    // fill writes still to issue, minus one
    logic        ramp_mode;

    // An odd-byte write completes a word and must own the port this edge.
    logic cpu_word;
    assign cpu_word = cpu_wr & cpu_addr[0];

    // Next fill value. The ramp carries only through the 15 colour bits.
    function automatic logic [15:0] next_val(input logic [15:0] v, input logic ramp);
        next_val = ramp ? {v[15], v[14:0] + 15'd1} : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            lo_latch  <= 8'd0;
            fill_ptr  <= 8'd0;
            fill_val  <= 16'd0;
            fill_rem  <= 8'd0;
            ramp_mode <= 1'b0;
            cram_addr <= 8'd0;
            cram_data <= 16'd0;
            cram_we   <= 1'b0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            cram_we   <= 1'b0;
            fill_done <= 1'b0;

            if (cpu_wr && !cpu_addr[0]) begin
                lo_latch <= cpu_data;
            end

            if (cpu_word) begin
                cram_we   <= 1'b1;
                cram_addr <= cpu_addr[8:1];
                cram_data <= {cpu_data, lo_latch};
            end

            case (state)
                S_IDLE: begin
                    if (fill_start) begin
                        ramp_mode <= fill_ramp;
                        fill_busy <= 1'b1;
                        if (!cpu_word) begin
                            // The first word goes out on the same edge that
                            // accepts the request. This saves one cycle of
                            // start-up latency.
                            cram_we   <= 1'b1;
                            cram_addr <= fill_base;
                            cram_data <= fill_data;
                            fill_ptr  <= fill_base + 8'd1;
                            fill_val  <= next_val(fill_data, fill_ramp);
                            fill_rem  <= fill_len - 8'd1;
                            state     <= (fill_len == 8'd0) ? S_DONE : S_RUN;
                        end else begin
                            // The port is taken by the CPU. All fill_len+1
                            // writes are still owed.
                            fill_ptr <= fill_base;
                            fill_val <= fill_data;
                            fill_rem <= fill_len;
                            state    <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (!cpu_word) begin
                        cram_we   <= 1'b1;
                        cram_addr <= fill_ptr;
                        cram_data <= fill_val;
                        fill_ptr  <= fill_ptr + 8'd1;
                        fill_val  <= next_val(fill_val, ramp_mode);
                        if (fill_rem == 8'd0) begin
                            state <= S_DONE;
                        end else begin
                            fill_rem <= fill_rem - 8'd1;
                        end
                    end
                end

                S_DONE: begin
                    // The cycle of the last fill write. Busy stays high
                    // through it, and done pulses on the cycle that follows.
                    fill_done <= 1'b1;
                    fill_busy <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/cram_writer.md
CRAM_WRITER -- requirements
Module: cram_writer

Interface
REQ-001 The module SHALL have no parameters; the CRAM is fixed at 256 x 16 bits.
REQ-002 clk  input  1  single system clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_wr  input  1  one-cycle byte-write strobe from the Z80 palette window.
REQ-005 cpu_addr  input  9  byte address in the 512-byte CRAM window; bit 0 selects the byte (0 = low, 1 = high).
REQ-006 cpu_data  input  8  byte write data.
REQ-007 fill_start  input  1  one-cycle request to start the fill engine.
REQ-008 fill_base  input  8  first CRAM word address of the fill.
REQ-009 fill_len  input  8  entry count minus 1 (0 = 1 entry, 255 = 256 entries).
REQ-010 fill_data  input  16  first fill word.
REQ-011 fill_ramp  input  1  0 = constant fill, 1 = ramp fill.
REQ-012 cram_addr  output  8  CRAM write word address.
REQ-013 cram_data  output  16  CRAM write data; bit 15 is the VDAC mode flag.
REQ-014 cram_we  output  1  CRAM write enable, one cycle per word.
REQ-015 fill_busy  output  1  fill engine active.
REQ-016 fill_done  output  1  one-cycle pulse when a fill completes.

Function
REQ-017 A cpu_wr with cpu_addr[0]=0 SHALL only load cpu_data into an internal low-byte latch and SHALL produce no CRAM write.
REQ-018 A cpu_wr with cpu_addr[0]=1 SHALL produce, in the following cycle, cram_we=1 with cram_addr=cpu_addr[8:1] and cram_data={cpu_data, low-byte latch}.
REQ-019 The low-byte latch SHALL persist across high-byte writes, so repeated odd writes reuse the last even byte.
REQ-020 All three CRAM port outputs (cram_addr, cram_data, cram_we) SHALL be registered; cram_we SHALL be 0 in every cycle that has no write.
REQ-021 The fill FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-022 IDLE: on fill_start, capture base, len, data and ramp; go to RUN; assert fill_busy from the next cycle.
REQ-023 RUN: each cycle the port is granted, write one word (addr ptr, data value) and decrement the remaining count.
REQ-024 RUN: after the (fill_len+1)th write, go to DONE.
REQ-025 DONE: assert fill_done for exactly one cycle, deassert fill_busy, return to IDLE.
REQ-026 The fill address pointer SHALL increment by 1 per write and wrap from 255 to 0.
REQ-027 In ramp mode, bits [14:0] SHALL increment by 1 per write, modulo 2^15; bit 15 SHALL stay at fill_data[15].
REQ-028 In constant mode, every fill write SHALL use fill_data.
REQ-029 Arbitration: a pending CPU word write SHALL win the port. The fill engine SHALL stall that cycle, keep its pointer, data and count unchanged, and resume next cycle.
REQ-030 A fill_start while fill_busy=1, or in the DONE cycle, SHALL be ignored.
REQ-031 A fill_start coincident with a CPU odd write SHALL be accepted; the first fill write is then delayed by one cycle.
REQ-032 CPU byte writes SHALL be accepted in every state, and CPU word writes SHALL never be dropped or delayed beyond one cycle.
REQ-033 Latency: fill_start at cycle N gives the first fill write at cycle N+1 when no CPU write is pending.
REQ-034 Latency: an uncontended fill of L+1 entries gives fill_done at cycle N+L+2.

Reset
REQ-035 While rst=1, the module SHALL hold: cram_we=0, cram_addr=0, cram_data=0, fill_busy=0, fill_done=0, low-byte latch=0, FSM=IDLE.
REQ-036 Asserting rst mid-fill SHALL abort the fill immediately, with no further writes and no fill_done pulse.
REQ-037 Asserting rst with a CPU word write pending SHALL discard that write.
REQ-038 After rst deasserts, the first clock edge SHALL accept new cpu_wr and fill_start inputs.

Verification
REQ-039 CPU word write: write 0x34 @0x010, then 0x92 @0x011 -> one cycle later, cram_we=1, addr=0x08, data=0x9234; no write after the even byte.
REQ-040 Latch reuse: after the REQ-039 sequence, write 0x11 @0x021 -> addr=0x10, data=0x1134.
REQ-041 Constant fill with wrap: base=0xFE, len=3, data=0x8001, ramp=0 -> 4 writes at addresses FE, FF, 00, 01, all data 0x8001; fill_done 5 cycles after start; fill_busy high for 4 cycles.
REQ-042 Ramp fill with collision: base=0x00, len=2, data=0xFFFE, ramp=1, plus a CPU odd write on the 2nd fill cycle -> fill writes 0xFFFE @00, 0xFFFF @01, 0x8000 @02, with the CPU word between them; fill_done one cycle late.
REQ-043 Reset mid-fill: len=255, rst asserted after 10 writes -> cram_we=0 at once, no fill_done, fill_busy=0; a new fill_start after release runs normally.
REQ-044 Ignored start: fill_start pulsed while busy with different base -> original fill completes unchanged and exactly one fill_done is seen.
